ook_demodulator: RTL and testbench

// - Receive-side counterpart of the on-off-keyed test-harness modulator: recovers data from a carrier-gated line.
// - Transmit carrier toggles every P = N+1 clocks, N = cycles_per_half_period; line = data AND carrier.
// - Declares carrier present (out=1) after a run of correctly spaced edges; absent (out=0) after a gap timeout.
// - Sits between the delay line under test and the harness UART result path; same mod_params word as the modulator.
//

---
 rtl/ook_demodulator_pkg.sv | 20 ++
 rtl/ook_edge_sync.sv | 30 +++
 rtl/ook_demodulator.sv | 157 +++++++++++++++
 tb/tb_ook_demodulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ook_demodulator_pkg.sv
// Shared constants and state encoding for the OOK demodulator.
// mod_params layout: N (cycles per half period) in the low N_W bits.
package ook_demodulator_pkg;

    localparam int MOD_PARAMS_W = 16;
    localparam int N_W          = 8;
    localparam int GAP_W        = N_W + 2;

    typedef enum logic [1:0] {
        OOK_IDLE   = 2'd0,
        OOK_ACQ    = 2'd1,
        OOK_LOCKED = 2'd2
    } ook_state_e;

    function automatic logic [31:0] win_lo(input logic [31:0] per,
                                           input logic [31:0] tol);
        return (per > tol) ? per - tol : 32'd1;
    endfunction

endpackage

// File: rtl/ook_edge_sync.sv
// Synchroniser for the asynchronous line plus a both-polarity edge pulse.
// The pulse is high for one cycle after the synced level changes.
module ook_edge_sync
    import ook_demodulator_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // shift the pin through the chain and remember the last synced level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/ook_demodulator.sv
// On-off-keyed carrier detector: edge-interval lock FSM and gap timeout.
// Define OOK_DEMOD_STATS_EN to build the lock/glitch statistics counters.
module ook_demodulator
    import ook_demodulator_pkg::*;
#(
    parameter int LOCK_EDGES  = 3,
    parameter int TOL         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_W      = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    in,
    input  logic [MOD_PARAMS_W-1:0] mod_params,
    output logic                    out,
    output logic                    glitch,
    output logic [STAT_W-1:0]       lock_count,
    output logic [STAT_W-1:0]       glitch_count
);

    localparam int RUN_W = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_EDGES - 1);

    ook_state_e              state_q, state_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [MOD_PARAMS_W-1:0] params_q;
    logic                    out_q, glitch_q, glitch_d;
    logic                    edge_det, params_chg;
    logic [31:0]             period, hi, lo, interval;
    logic                    too_short, too_long;

    ook_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (n_reset),
        .d_i    (in),
        .edge_o (edge_det)
    );

    assign params_chg = (mod_params != params_q);
    assign period     = 32'(params_q[N_W-1:0]) + 32'd1;
    assign hi         = period + 32'(TOL);
    assign lo         = win_lo(period, 32'(TOL));
    assign interval   = 32'(gap_q) + 32'd1;
    assign too_short  = interval < lo;
    assign too_long   = interval > hi;

    // next state: judge each edge against the window, time out on silence
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        glitch_d = 1'b0;
        gap_d    = edge_det ? '0 :
                   (gap_q == '1) ? gap_q : gap_q + GAP_W'(1);
        unique case (state_q)
            OOK_IDLE: begin
                if (edge_det) begin
                    state_d = OOK_ACQ;
                    run_d   = '0;
                end
            end
            OOK_ACQ: begin
                if (edge_det) begin
                    if (too_short) begin
                        glitch_d = 1'b1;
                        state_d  = OOK_IDLE;
                        run_d    = '0;
                    end else if (too_long) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d = OOK_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else if (too_long) begin
                    state_d = OOK_IDLE;
                    run_d   = '0;
                end
            end
            OOK_LOCKED: begin
                if (edge_det) begin
                    if (too_short) begin
                        glitch_d = 1'b1;
                        state_d  = OOK_IDLE;
                    end else if (too_long) begin
                        state_d = OOK_ACQ;
                        run_d   = '0;
                    end
                end else if (too_long) begin
                    state_d = OOK_IDLE;
                end
            end
            default: begin
                state_d = OOK_IDLE;
                run_d   = '0;
            end
        endcase
        if (params_chg) begin
            state_d  = OOK_IDLE;
            run_d    = '0;
            gap_d    = '0;
            glitch_d = 1'b0;
        end
    end

    // state, gap counter, parameter shadow and registered outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= OOK_IDLE;
            run_q    <= '0;
            gap_q    <= '0;
            params_q <= '0;
            out_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            gap_q    <= gap_d;
            params_q <= mod_params;
            out_q    <= (state_d == OOK_LOCKED);
            glitch_q <= glitch_d;
        end
    end

    assign out    = out_q;
    assign glitch = glitch_q;

`ifdef OOK_DEMOD_STATS_EN
    logic              lock_entry;
    logic [STAT_W-1:0] lock_cnt_q, glitch_cnt_q;

    assign lock_entry = (state_d == OOK_LOCKED) && (state_q != OOK_LOCKED);

    // saturating event counters
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lock_cnt_q   <= '0;
            glitch_cnt_q <= '0;
        end else begin
            if (lock_entry && (lock_cnt_q != '1))
                lock_cnt_q <= lock_cnt_q + STAT_W'(1);
            if (glitch_d && (glitch_cnt_q != '1))
                glitch_cnt_q <= glitch_cnt_q + STAT_W'(1);
        end
    end

    assign lock_count   = lock_cnt_q;
    assign glitch_count = glitch_cnt_q;
`else
    assign lock_count   = '0;
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_ook_demodulator.sv
// Self-checking bench for ook_demodulator: directed and random line traces
// compared cycle by cycle against an edge-event reference model.
module tb_ook_demodulator;
    import ook_demodulator_pkg::*;

    localparam int LOCK_EDGES = 3;
    localparam int TOL        = 2;
    localparam int SYNC       = 2;
    localparam int STAT_W     = 16;
    localparam int MAXL       = 512;
`ifdef OOK_DEMOD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    n_reset = 1'b0;
    logic                    in = 1'b0;
    logic [MOD_PARAMS_W-1:0] mod_params = '0;
    logic                    out, glitch;
    logic [STAT_W-1:0]       lock_count, glitch_count;

    int tests = 0;
    int fails = 0;
    int len;
    int exp_locks, exp_glitches;

    logic tg      [0:MAXL];
    logic v       [0:MAXL];
    logic obs_out [0:MAXL];
    logic obs_gl  [0:MAXL];
    logic exp_out [0:MAXL];
    logic exp_gl  [0:MAXL];

    ook_demodulator #(
        .LOCK_EDGES  (LOCK_EDGES),
        .TOL         (TOL),
        .SYNC_STAGES (SYNC),
        .STAT_W      (STAT_W)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .in           (in),
        .mod_params   (mod_params),
        .out          (out),
        .glitch       (glitch),
        .lock_count   (lock_count),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int hi_of(input int n);
        return n + 1 + TOL;
    endfunction

    function automatic int lo_of(input int n);
        return (n + 1 - TOL < 1) ? 1 : n + 1 - TOL;
    endfunction

    task automatic clear_trace();
        for (int i = 0; i <= MAXL; i++) tg[i] = 1'b0;
    endtask

    task automatic toggles(input int from, input int upto, input int step);
        for (int t = from; t <= upto; t += step) tg[t] = 1'b1;
    endtask

    task automatic finish_trace(input int l);
        len  = l;
        v[0] = 1'b0;
        for (int i = 1; i <= MAXL; i++) v[i] = v[i-1] ^ tg[i];
    endtask

    task automatic mark(input int s, input int t);
        for (int i = s; i < t && i <= len; i++) exp_out[i] = 1'b1;
    endtask

    // Reference: a pin toggle at cycle k is seen as an edge decided at
    // posedge k+SYNC; the interval to the previous edge selects lock,
    // glitch or restart; silence past the window ends any lock.
    task automatic model(input int n1, input int n2, input int c);
        bit anchored, locked, e;
        int cnt, last, lstart, n;
        anchored = 0; locked = 0; cnt = 0; last = 0; lstart = 0;
        exp_locks = 0; exp_glitches = 0;
        for (int i = 0; i <= MAXL; i++) begin
            exp_out[i] = 1'b0;
            exp_gl[i]  = 1'b0;
        end
        for (int d = 1; d <= len; d++) begin
            n = (c > 0 && d > c) ? n2 : n1;
            e = (d > SYNC) && (v[d-SYNC] != v[d-SYNC-1]);
            if (d == c) begin
                if (locked) mark(lstart, d);
                locked = 0; anchored = 0; last = d;
                continue;
            end
            if (anchored && (d - last > hi_of(n))) begin
                if (locked) mark(lstart, d);
                locked = 0; anchored = 0;
            end
            if (e) begin
                if (!anchored) begin
                    anchored = 1; cnt = 0;
                end else if (d - last < lo_of(n)) begin
                    exp_gl[d] = 1'b1;
                    exp_glitches++;
                    if (locked) mark(lstart, d);
                    locked = 0; anchored = 0;
                end else if (!locked) begin
                    cnt++;
                    if (cnt == LOCK_EDGES) begin
                        locked = 1; lstart = d; exp_locks++;
                    end
                end
                last = d;
            end
        end
        if (locked) mark(lstart, len + 1);
    endtask

    task automatic run_scn(input string name, input int n1, input int n2,
                           input int c);
        n_reset    = 1'b0;
        in         = 1'b0;
        mod_params = MOD_PARAMS_W'(n1);
        repeat (2) @(posedge clk);
        #1;
        check({name, ".rst_out"}, 32'(out), 0);
        check({name, ".rst_lockcnt"}, 32'(lock_count), 0);
        n_reset = 1'b1;
        for (int k = 1; k <= len; k++) begin
            if (c > 0 && k >= c) mod_params = MOD_PARAMS_W'(n2);
            in = v[k];
            @(posedge clk);
            #1;
            obs_out[k] = out;
            obs_gl[k]  = glitch;
        end
        model(n1, n2, c);
        for (int k = 1; k <= len; k++) begin
            check($sformatf("%s.out@%0d", name, k),
                  32'(obs_out[k]), 32'(exp_out[k]));
            check($sformatf("%s.glitch@%0d", name, k),
                  32'(obs_gl[k]), 32'(exp_gl[k]));
        end
        check({name, ".lock_count"}, 32'(lock_count),
              STATS ? 32'(exp_locks) : 0);
        check({name, ".glitch_count"}, 32'(glitch_count),
              STATS ? 32'(exp_glitches) : 0);
    endtask

    function automatic int find_out(input int from, input logic val);
        for (int k = from; k <= len; k++)
            if (obs_out[k] === val) return k;
        return -1;
    endfunction

    initial begin
        int r, f, any, n, lo, hi, t, x;

        // steady carrier N=4 for 100 cycles, then line low
        clear_trace();
        toggles(5, 100, 5);
        finish_trace(130);
        run_scn("lock5", 4, 4, 0);
        r = find_out(1, 1'b1);
        check("lock5.rise_cycle", r, 5 + LOCK_EDGES * 5 + SYNC);
        f = find_out(r, 1'b0);
        check("lock5.fall_cycle", f, 100 + SYNC - 1 + (5 + TOL + 2));

        // locked, then two edges 2 clocks apart
        clear_trace();
        toggles(5, 40, 5);
        toggles(42, 44, 2);
        finish_trace(70);
        run_scn("glitch", 4, 4, 0);
        check("glitch.pulse", 32'(obs_gl[42 + SYNC]), 1);
        check("glitch.pulse_end", 32'(obs_gl[43 + SYNC]), 0);
        check("glitch.out_before", 32'(obs_out[41 + SYNC]), 1);
        check("glitch.out_after", 32'(obs_out[42 + SYNC]), 0);

        // intervals at the window edges 3 and 7 are accepted
        clear_trace();
        tg[5] = 1; tg[8] = 1; tg[15] = 1; tg[18] = 1; tg[25] = 1;
        tg[28] = 1;
        finish_trace(50);
        run_scn("win37", 4, 4, 0);
        check("win37.rise_cycle", find_out(1, 1'b1), 18 + SYNC);

        // alternating 8/5 never locks
        clear_trace();
        t = 5;
        tg[t] = 1;
        for (int i = 0; i < 8; i++) begin
            t += (i % 2 == 0) ? 8 : 5;
            tg[t] = 1;
        end
        finish_trace(t + 15);
        run_scn("alt85", 4, 4, 0);
        any = 0;
        for (int k = 1; k <= len; k++) if (obs_out[k] === 1'b1) any = 1;
        check("alt85.never_locked", any, 0);

        // N=0: line toggling every clock, then stopped
        clear_trace();
        toggles(1, 20, 1);
        finish_trace(40);
        run_scn("n0", 0, 0, 0);
        r = find_out(1, 1'b1);
        check("n0.rise_cycle", r, 1 + SYNC + LOCK_EDGES);
        check("n0.fall_cycle", find_out(r, 1'b0), 20 + SYNC + 4);

        // N changes 4 -> 6 while locked, relock on the new period
        clear_trace();
        toggles(5, 45, 5);
        toggles(52, 150, 7);
        finish_trace(175);
        run_scn("chg", 4, 6, 50);
        check("chg.out_before", 32'(obs_out[49]), 1);
        check("chg.out_at_change", 32'(obs_out[50]), 0);

        // asynchronous reset while locked
        n_reset    = 1'b0;
        in         = 1'b0;
        mod_params = MOD_PARAMS_W'(4);
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            in = ((k / 5) % 2) != 0;
            @(posedge clk);
            #1;
        end
        check("midrst.pre_out", 32'(out), 1);
        check("midrst.pre_lockcnt", 32'(lock_count), STATS ? 1 : 0);
        #2;
        n_reset = 1'b0;
        #1;
        check("midrst.out", 32'(out), 0);
        check("midrst.glitch", 32'(glitch), 0);
        check("midrst.lockcnt", 32'(lock_count), 0);
        check("midrst.glitchcnt", 32'(glitch_count), 0);
        clear_trace();
        toggles(5, 60, 5);
        finish_trace(80);
        run_scn("relock", 4, 4, 0);

        // random interval sequences around the window
        for (int s = 0; s < 6; s++) begin
            n  = $urandom_range(0, 6);
            lo = lo_of(n);
            hi = hi_of(n);
            clear_trace();
            t = 5;
            tg[t] = 1;
            for (int i = 0; i < 25; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7)
                    x = $urandom_range(lo, hi);
                else if (r < 8 && lo > 1)
                    x = $urandom_range(1, lo - 1);
                else
                    x = $urandom_range(hi + 1, hi + 3);
                t += x;
                tg[t] = 1;
            end
            finish_trace(t + hi + 6);
            run_scn($sformatf("rnd%0d_n%0d", s, n), n, n, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
